rob_multi: RTL and testbench

- Parametrised reorder buffer: next generation of the single-commit ROB.
- Allocates entries in program order at issue and collects results from three completion sources (ALU, load, store).
- Retires up to COMMIT_W consecutive completed entries per cycle in order.
- Adds over the previous block: full/occupancy reporting, same-cycle writeback bypass on operand lookup, and partial flush (drop only entries younger than a given position) alongside full flush.

---
 rtl/rob_multi_if.sv | 72 +++++++
 rtl/rob_multi.sv | 191 +++++++++++++++++++
 tb/tb_rob_multi.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_multi_if.sv
// Issue, completion, operand lookup, flush and retirement signals of the
// reorder buffer; the buffer itself takes the slave side.
interface rob_multi_if #(
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned INSTR_W  = 6,
  parameter int unsigned LSB_W    = 3
);
  logic                         rdy_in;
  logic                         issue_en_in;
  logic [INSTR_W-1:0]           issue_instr_id_in;
  logic [REG_W-1:0]             issue_rd_in;
  logic [LSB_W-1:0]             issue_lsb_pos_in;
  logic [ADDR_W-1:0]            issue_pc_in;
  logic [IDX_W-1:0]             alloc_pos_out;
  logic                         full_out;
  logic                         empty_out;
  logic [IDX_W:0]               count_out;
  logic                         ex_wb_en_in;
  logic [IDX_W-1:0]             ex_wb_pos_in;
  logic [DATA_W-1:0]            ex_res_in;
  logic                         ex_jump_en_in;
  logic [ADDR_W-1:0]            ex_jump_a_in;
  logic                         ld_wb_en_in;
  logic [IDX_W-1:0]             ld_wb_pos_in;
  logic [DATA_W-1:0]            ld_res_in;
  logic                         st_done_en_in;
  logic [IDX_W-1:0]             st_done_pos_in;
  logic [IDX_W-1:0]             rs1_pos_in;
  logic [IDX_W-1:0]             rs2_pos_in;
  logic                         rs1_ready_out;
  logic                         rs2_ready_out;
  logic [DATA_W-1:0]            rs1_res_out;
  logic [DATA_W-1:0]            rs2_res_out;
  logic                         flush_all_in;
  logic                         flush_part_en_in;
  logic [IDX_W-1:0]             flush_part_pos_in;
  logic [COMMIT_W-1:0]          commit_en_out;
  logic [COMMIT_W*INSTR_W-1:0]  commit_instr_id_out;
  logic [COMMIT_W*REG_W-1:0]    commit_rd_out;
  logic [COMMIT_W*IDX_W-1:0]    commit_pos_out;
  logic [COMMIT_W*LSB_W-1:0]    commit_lsb_pos_out;
  logic [COMMIT_W*DATA_W-1:0]   commit_res_out;
  logic [COMMIT_W*ADDR_W-1:0]   commit_pc_out;
  logic [COMMIT_W-1:0]          commit_jump_en_out;
  logic [COMMIT_W*ADDR_W-1:0]   commit_jump_a_out;

  modport master (
    output rdy_in, issue_en_in, issue_instr_id_in, issue_rd_in, issue_lsb_pos_in, issue_pc_in,
    output ex_wb_en_in, ex_wb_pos_in, ex_res_in, ex_jump_en_in, ex_jump_a_in,
    output ld_wb_en_in, ld_wb_pos_in, ld_res_in, st_done_en_in, st_done_pos_in,
    output rs1_pos_in, rs2_pos_in, flush_all_in, flush_part_en_in, flush_part_pos_in,
    input  alloc_pos_out, full_out, empty_out, count_out,
    input  rs1_ready_out, rs2_ready_out, rs1_res_out, rs2_res_out,
    input  commit_en_out, commit_instr_id_out, commit_rd_out, commit_pos_out, commit_lsb_pos_out,
    input  commit_res_out, commit_pc_out, commit_jump_en_out, commit_jump_a_out
  );

  modport slave (
    input  rdy_in, issue_en_in, issue_instr_id_in, issue_rd_in, issue_lsb_pos_in, issue_pc_in,
    input  ex_wb_en_in, ex_wb_pos_in, ex_res_in, ex_jump_en_in, ex_jump_a_in,
    input  ld_wb_en_in, ld_wb_pos_in, ld_res_in, st_done_en_in, st_done_pos_in,
    input  rs1_pos_in, rs2_pos_in, flush_all_in, flush_part_en_in, flush_part_pos_in,
    output alloc_pos_out, full_out, empty_out, count_out,
    output rs1_ready_out, rs2_ready_out, rs1_res_out, rs2_res_out,
    output commit_en_out, commit_instr_id_out, commit_rd_out, commit_pos_out, commit_lsb_pos_out,
    output commit_res_out, commit_pc_out, commit_jump_en_out, commit_jump_a_out
  );
endinterface

// File: rtl/rob_multi.sv
// Reorder buffer: in-order allocation, three completion sources, up to
// COMMIT_W in-order retirements per cycle, operand bypass and partial flush.
module rob_multi #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned INSTR_W  = 6,
  parameter int unsigned LSB_W    = 3
) (
  input logic        clk_in,
  input logic        rst_n_in,
  rob_multi_if.slave rob
);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]   head, tail, head_nxt, tail_nxt, count, n_cmt;
  logic [DEPTH-1:0]   valid, done, jump_en;
  logic [DEPTH-1:0]   valid_nxt, done_nxt, jump_en_nxt;
  logic [INSTR_W-1:0] instr_id_q [DEPTH];
  logic [REG_W-1:0]   rd_q       [DEPTH];
  logic [LSB_W-1:0]   lsb_q      [DEPTH];
  logic [ADDR_W-1:0]  pc_q       [DEPTH];
  logic [DATA_W-1:0]  res_q      [DEPTH];
  logic [ADDR_W-1:0]  jump_a_q   [DEPTH];

  logic               full, empty;
  logic [IDX_W-1:0]   head_idx, tail_idx, fp_off;
  logic               ex_ok, ld_ok, st_ok, fp_ok, issue_ok, commit_go;
  logic [COMMIT_W-1:0] cmt;
  logic [IDX_W-1:0]   slot_idx [COMMIT_W];
  logic [IDX_W-1:0]   lk_pos [2];
  logic               lk_rdy [2];
  logic [DATA_W-1:0]  lk_res [2];

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign count    = tail - head;
  assign full     = (count == PTR_W'(DEPTH));
  assign empty    = (count == '0);

  assign rob.alloc_pos_out = tail_idx;
  assign rob.full_out      = full;
  assign rob.empty_out     = empty;
  assign rob.count_out     = count;

  // Qualified events; a load and an ALU result to the same slot keep the load.
  always_comb begin
    ld_ok     = rob.ld_wb_en_in && valid[rob.ld_wb_pos_in];
    ex_ok     = rob.ex_wb_en_in && valid[rob.ex_wb_pos_in] &&
                !(rob.ld_wb_en_in && (rob.ld_wb_pos_in == rob.ex_wb_pos_in));
    st_ok     = rob.st_done_en_in && valid[rob.st_done_pos_in];
    fp_ok     = !rob.flush_all_in && rob.flush_part_en_in && valid[rob.flush_part_pos_in];
    issue_ok  = rob.issue_en_in && !full && !fp_ok && !rob.flush_all_in;
    commit_go = rob.rdy_in && !rob.flush_all_in && !fp_ok;
    fp_off    = rob.flush_part_pos_in - head_idx;
  end

  // Retire a run of done entries from head; a redirect closes the group.
  always_comb begin
    cmt   = '0;
    n_cmt = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_idx[k] = head_idx + IDX_W'(k);
    end
    cmt[0] = commit_go && valid[slot_idx[0]] && done[slot_idx[0]];
    for (int k = 1; k < COMMIT_W; k++) begin
      cmt[k] = cmt[k-1] && valid[slot_idx[k]] && done[slot_idx[k]] && !jump_en[slot_idx[k-1]];
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      n_cmt = n_cmt + PTR_W'(cmt[k]);
    end
  end

  always_comb begin
    logic [IDX_W-1:0] off_i;
    valid_nxt   = valid;
    done_nxt    = done;
    jump_en_nxt = jump_en;
    head_nxt    = head + n_cmt;
    tail_nxt    = tail;
    off_i       = '0;
    if (ex_ok) begin
      done_nxt[rob.ex_wb_pos_in]    = 1'b1;
      jump_en_nxt[rob.ex_wb_pos_in] = rob.ex_jump_en_in;
    end
    if (ld_ok) done_nxt[rob.ld_wb_pos_in] = 1'b1;
    if (st_ok) done_nxt[rob.st_done_pos_in] = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (cmt[k]) valid_nxt[slot_idx[k]] = 1'b0;
    end
    // Age is the distance from head; everything older than the survivor stays.
    if (fp_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        off_i = IDX_W'(i) - head_idx;
        if (off_i > fp_off) valid_nxt[i] = 1'b0;
      end
      tail_nxt = head + PTR_W'(fp_off) + PTR_W'(1);
    end
    if (issue_ok) begin
      valid_nxt[tail_idx]   = 1'b1;
      done_nxt[tail_idx]    = 1'b0;
      jump_en_nxt[tail_idx] = 1'b0;
      tail_nxt              = tail + PTR_W'(1);
    end
    if (rob.flush_all_in) begin
      valid_nxt   = '0;
      done_nxt    = '0;
      jump_en_nxt = '0;
      head_nxt    = '0;
      tail_nxt    = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head                    <= '0;
      tail                    <= '0;
      valid                   <= '0;
      done                    <= '0;
      jump_en                 <= '0;
      rob.commit_en_out       <= '0;
      rob.commit_instr_id_out <= '0;
      rob.commit_rd_out       <= '0;
      rob.commit_pos_out      <= '0;
      rob.commit_lsb_pos_out  <= '0;
      rob.commit_res_out      <= '0;
      rob.commit_pc_out       <= '0;
      rob.commit_jump_en_out  <= '0;
      rob.commit_jump_a_out   <= '0;
    end else begin
      rob.commit_en_out <= cmt;
      if (rob.rdy_in) begin
        head    <= head_nxt;
        tail    <= tail_nxt;
        valid   <= valid_nxt;
        done    <= done_nxt;
        jump_en <= jump_en_nxt;
        for (int k = 0; k < COMMIT_W; k++) begin
          rob.commit_instr_id_out[k*INSTR_W +: INSTR_W] <= instr_id_q[slot_idx[k]];
          rob.commit_rd_out[k*REG_W +: REG_W]           <= rd_q[slot_idx[k]];
          rob.commit_pos_out[k*IDX_W +: IDX_W]          <= slot_idx[k];
          rob.commit_lsb_pos_out[k*LSB_W +: LSB_W]      <= lsb_q[slot_idx[k]];
          rob.commit_res_out[k*DATA_W +: DATA_W]        <= res_q[slot_idx[k]];
          rob.commit_pc_out[k*ADDR_W +: ADDR_W]         <= pc_q[slot_idx[k]];
          rob.commit_jump_en_out[k]                     <= jump_en[slot_idx[k]];
          rob.commit_jump_a_out[k*ADDR_W +: ADDR_W]     <= jump_a_q[slot_idx[k]];
        end
      end
    end
  end

  // Payload storage needs no reset: validity is tracked separately.
  always_ff @(posedge clk_in) begin
    if (rob.rdy_in) begin
      if (issue_ok) begin
        instr_id_q[tail_idx] <= rob.issue_instr_id_in;
        rd_q[tail_idx]       <= rob.issue_rd_in;
        lsb_q[tail_idx]      <= rob.issue_lsb_pos_in;
        pc_q[tail_idx]       <= rob.issue_pc_in;
      end
      if (ex_ok) begin
        res_q[rob.ex_wb_pos_in]    <= rob.ex_res_in;
        jump_a_q[rob.ex_wb_pos_in] <= rob.ex_jump_a_in;
      end
      if (ld_ok) res_q[rob.ld_wb_pos_in] <= rob.ld_res_in;
    end
  end

  // Operand lookup with same-cycle bypass of ALU and load results.
  always_comb begin
    logic lk_ex, lk_ld;
    lk_pos[0] = rob.rs1_pos_in;
    lk_pos[1] = rob.rs2_pos_in;
    lk_ex     = 1'b0;
    lk_ld     = 1'b0;
    for (int p = 0; p < 2; p++) begin
      lk_ex     = rob.ex_wb_en_in && (rob.ex_wb_pos_in == lk_pos[p]);
      lk_ld     = rob.ld_wb_en_in && (rob.ld_wb_pos_in == lk_pos[p]);
      lk_rdy[p] = valid[lk_pos[p]] && (done[lk_pos[p]] || lk_ex || lk_ld);
      lk_res[p] = lk_ld ? rob.ld_res_in : (lk_ex ? rob.ex_res_in : res_q[lk_pos[p]]);
    end
  end

  assign rob.rs1_ready_out = lk_rdy[0];
  assign rob.rs2_ready_out = lk_rdy[1];
  assign rob.rs1_res_out   = lk_res[0];
  assign rob.rs2_res_out   = lk_res[1];
endmodule

// File: tb/tb_rob_multi.sv
// Bench for rob_multi: directed table, hand sequences and a queue-based
// reference model driven with random traffic.
module tb_rob_multi;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDX_W = 4;

  logic clk_in = 1'b0;
  logic rst_n_in;
  always #5 clk_in = ~clk_in;

  rob_multi_if bus ();
  rob_multi dut (.clk_in(clk_in), .rst_n_in(rst_n_in), .rob(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          pos;
    logic [5:0]  id;
    logic [4:0]  rd;
    logic [2:0]  lsb;
    logic [31:0] pc;
    bit          done;
    bit          res_known;
    logic [31:0] res;
    bit          jmp;
    logic [31:0] ja;
  } ent_t;

  typedef struct {
    bit          iss;
    bit          ex_en;
    logic [3:0]  ex_pos;
    bit          ex_jmp;
    logic [31:0] ex_res;
    logic [1:0]  e_cen;
    logic [4:0]  e_cnt;
    logic [3:0]  e_p0;
    logic [3:0]  e_p1;
    bit          e_j0;
    logic [31:0] e_r0;
  } vec_t;

  ent_t       q[$];
  int         m_hd;
  logic [1:0] exp_cen;
  ent_t       exp_slot[2];
  vec_t       tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.rdy_in = 1'b1;
    bus.issue_en_in = 1'b0; bus.issue_instr_id_in = '0; bus.issue_rd_in = '0;
    bus.issue_lsb_pos_in = '0; bus.issue_pc_in = '0;
    bus.ex_wb_en_in = 1'b0; bus.ex_wb_pos_in = '0; bus.ex_res_in = '0;
    bus.ex_jump_en_in = 1'b0; bus.ex_jump_a_in = '0;
    bus.ld_wb_en_in = 1'b0; bus.ld_wb_pos_in = '0; bus.ld_res_in = '0;
    bus.st_done_en_in = 1'b0; bus.st_done_pos_in = '0;
    bus.rs1_pos_in = '0; bus.rs2_pos_in = '0;
    bus.flush_all_in = 1'b0; bus.flush_part_en_in = 1'b0; bus.flush_part_pos_in = '0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    chk("rst_empty", bus.empty_out, 1);
    chk("rst_full", bus.full_out, 0);
    chk("rst_count", bus.count_out, 0);
    chk("rst_commit_en", bus.commit_en_out, 0);
    chk("rst_commit_pc", bus.commit_pc_out, 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    q.delete();
    m_hd = 0;
    tick();
  endtask

  function automatic int find(input logic [3:0] p);
    for (int i = 0; i < q.size(); i++) if (q[i].pos == int'(p)) return i;
    return -1;
  endfunction

  function automatic logic [3:0] pick_pos();
    if (q.size() > 0 && $urandom_range(0, 3) != 0)
      return 4'(q[$urandom_range(0, q.size() - 1)].pos);
    return 4'($urandom);
  endfunction

  task automatic rand_inputs();
    bus.rdy_in            = ($urandom_range(0, 9) != 0);
    bus.issue_en_in       = ($urandom_range(0, 9) < 6);
    bus.issue_instr_id_in = 6'($urandom);
    bus.issue_rd_in       = 5'($urandom);
    bus.issue_lsb_pos_in  = 3'($urandom);
    bus.issue_pc_in       = $urandom;
    bus.ex_wb_en_in       = ($urandom_range(0, 2) != 0);
    bus.ex_wb_pos_in      = pick_pos();
    bus.ex_res_in         = $urandom;
    bus.ex_jump_en_in     = ($urandom_range(0, 4) == 0);
    bus.ex_jump_a_in      = $urandom;
    bus.ld_wb_en_in       = ($urandom_range(0, 2) == 0);
    bus.ld_wb_pos_in      = pick_pos();
    bus.ld_res_in         = $urandom;
    if (bus.ex_wb_en_in && bus.ld_wb_pos_in == bus.ex_wb_pos_in) bus.ld_wb_en_in = 1'b0;
    bus.st_done_en_in     = ($urandom_range(0, 4) == 0);
    bus.st_done_pos_in    = pick_pos();
    bus.rs1_pos_in        = pick_pos();
    bus.rs2_pos_in        = pick_pos();
    bus.flush_all_in      = ($urandom_range(0, 99) < 2);
    bus.flush_part_en_in  = ($urandom_range(0, 99) < 4);
    bus.flush_part_pos_in = pick_pos();
  endtask

  task automatic check_lookup(input string nm, input logic [3:0] p, input logic r_act,
                              input logic [31:0] v_act);
    int   i   = find(p);
    bit   exh = bus.ex_wb_en_in && (bus.ex_wb_pos_in == p);
    bit   ldh = bus.ld_wb_en_in && (bus.ld_wb_pos_in == p);
    bit   r   = 1'b0;
    bit   known = 1'b0;
    logic [31:0] v = '0;
    if (i >= 0) begin
      r = q[i].done || exh || ldh;
      if (ldh)      begin v = bus.ld_res_in; known = 1'b1; end
      else if (exh) begin v = bus.ex_res_in; known = 1'b1; end
      else          begin v = q[i].res; known = q[i].res_known; end
    end
    chk({nm, "_ready"}, r_act, r);
    if (r && known) chk({nm, "_res"}, v_act, v);
  endtask

  task automatic check_comb();
    chk("count", bus.count_out, q.size());
    chk("full", bus.full_out, q.size() == DEPTH);
    chk("empty", bus.empty_out, q.size() == 0);
    chk("alloc_pos", bus.alloc_pos_out, (m_hd + q.size()) % DEPTH);
    check_lookup("rs1", bus.rs1_pos_in, bus.rs1_ready_out, bus.rs1_res_out);
    check_lookup("rs2", bus.rs2_pos_in, bus.rs2_ready_out, bus.rs2_res_out);
  endtask

  // Applies this cycle's inputs to the model at the clock edge.
  task automatic model_edge();
    int   sz, alloc, fi, n, xi;
    bit   fp_ok;
    ent_t e;
    exp_cen = 2'b00;
    if (!bus.rdy_in) return;
    if (bus.flush_all_in) begin
      q.delete();
      m_hd = 0;
      return;
    end
    sz    = q.size();
    alloc = (m_hd + sz) % DEPTH;
    fi    = find(bus.flush_part_pos_in);
    fp_ok = bus.flush_part_en_in && (fi >= 0);
    n = 0;
    if (!fp_ok && sz > 0 && q[0].done) begin
      n = 1;
      if (sz > 1 && q[1].done && !q[0].jmp) n = 2;
    end
    for (int k = 0; k < n; k++) begin
      exp_slot[k] = q[k];
      exp_cen[k]  = 1'b1;
    end
    xi = find(bus.ex_wb_pos_in);
    if (bus.ex_wb_en_in && xi >= 0 && !(bus.ld_wb_en_in && bus.ld_wb_pos_in == bus.ex_wb_pos_in)) begin
      q[xi].done = 1'b1; q[xi].res = bus.ex_res_in; q[xi].res_known = 1'b1;
      q[xi].jmp = bus.ex_jump_en_in; q[xi].ja = bus.ex_jump_a_in;
    end
    xi = find(bus.ld_wb_pos_in);
    if (bus.ld_wb_en_in && xi >= 0) begin
      q[xi].done = 1'b1; q[xi].res = bus.ld_res_in; q[xi].res_known = 1'b1;
    end
    xi = find(bus.st_done_pos_in);
    if (bus.st_done_en_in && xi >= 0) q[xi].done = 1'b1;
    for (int k = 0; k < n; k++) void'(q.pop_front());
    m_hd = (m_hd + n) % DEPTH;
    if (fp_ok) while (q.size() > fi + 1) void'(q.pop_back());
    if (bus.issue_en_in && sz < DEPTH && !fp_ok) begin
      e = '{pos: alloc, id: bus.issue_instr_id_in, rd: bus.issue_rd_in, lsb: bus.issue_lsb_pos_in,
            pc: bus.issue_pc_in, done: 1'b0, res_known: 1'b0, res: '0, jmp: 1'b0, ja: '0};
      q.push_back(e);
    end
  endtask

  task automatic check_commit();
    chk("commit_en", bus.commit_en_out, exp_cen);
    for (int k = 0; k < 2; k++) begin
      if (exp_cen[k]) begin
        chk("c_pos", bus.commit_pos_out[k*4 +: 4], 64'(exp_slot[k].pos));
        chk("c_id", bus.commit_instr_id_out[k*6 +: 6], exp_slot[k].id);
        chk("c_rd", bus.commit_rd_out[k*5 +: 5], exp_slot[k].rd);
        chk("c_lsb", bus.commit_lsb_pos_out[k*3 +: 3], exp_slot[k].lsb);
        chk("c_pc", bus.commit_pc_out[k*32 +: 32], exp_slot[k].pc);
        chk("c_jump_en", bus.commit_jump_en_out[k], exp_slot[k].jmp);
        if (exp_slot[k].res_known) chk("c_res", bus.commit_res_out[k*32 +: 32], exp_slot[k].res);
        if (exp_slot[k].jmp) chk("c_jump_a", bus.commit_jump_a_out[k*32 +: 32], exp_slot[k].ja);
      end
    end
  endtask

  initial begin
    rst_n_in = 1'b0;
    idle();
    //            iss   ex    pos    jmp   res       cen    cnt   p0     p1     j0    r0
    tbl[0]  = '{1'b1, 1'b0, 4'd0, 1'b0, 32'h0,  2'b00, 5'd1, 4'd0, 4'd0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'd0, 1'b0, 32'h0,  2'b00, 5'd2, 4'd0, 4'd0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 4'd1, 1'b0, 32'h11, 2'b00, 5'd2, 4'd0, 4'd0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 4'd0, 1'b0, 32'h10, 2'b00, 5'd2, 4'd0, 4'd0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 4'd0, 1'b0, 32'h0,  2'b11, 5'd0, 4'd0, 4'd1, 1'b0, 32'h10};
    tbl[5]  = '{1'b0, 1'b0, 4'd0, 1'b0, 32'h0,  2'b00, 5'd0, 4'd0, 4'd0, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 4'd0, 1'b0, 32'h0,  2'b00, 5'd1, 4'd0, 4'd0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 4'd0, 1'b0, 32'h0,  2'b00, 5'd2, 4'd0, 4'd0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 4'd3, 1'b0, 32'h33, 2'b00, 5'd2, 4'd0, 4'd0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 4'd2, 1'b1, 32'h22, 2'b00, 5'd2, 4'd0, 4'd0, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 32'h0,  2'b01, 5'd1, 4'd2, 4'd0, 1'b1, 32'h22};
    tbl[11] = '{1'b0, 1'b0, 4'd0, 1'b0, 32'h0,  2'b01, 5'd0, 4'd3, 4'd0, 1'b0, 32'h33};
    tbl[12] = '{1'b0, 1'b0, 4'd0, 1'b0, 32'h0,  2'b00, 5'd0, 4'd0, 4'd0, 1'b0, 32'h0};

    // Dual commit and redirect-terminated groups
    do_reset();
    for (int r = 0; r < 13; r++) begin
      idle();
      bus.issue_en_in       = tbl[r].iss;
      bus.issue_instr_id_in = 6'(r);
      bus.issue_pc_in       = 32'h1000 + 32'(r * 4);
      bus.ex_wb_en_in       = tbl[r].ex_en;
      bus.ex_wb_pos_in      = tbl[r].ex_pos;
      bus.ex_jump_en_in     = tbl[r].ex_jmp;
      bus.ex_jump_a_in      = 32'h8000;
      bus.ex_res_in         = tbl[r].ex_res;
      tick();
      chk("tbl_commit_en", bus.commit_en_out, tbl[r].e_cen);
      chk("tbl_count", bus.count_out, tbl[r].e_cnt);
      chk("tbl_empty", bus.empty_out, tbl[r].e_cnt == 5'd0);
      if (tbl[r].e_cen[0]) begin
        chk("tbl_pos0", bus.commit_pos_out[3:0], tbl[r].e_p0);
        chk("tbl_jump0", bus.commit_jump_en_out[0], tbl[r].e_j0);
        chk("tbl_res0", bus.commit_res_out[31:0], tbl[r].e_r0);
      end
      if (tbl[r].e_cen[1]) chk("tbl_pos1", bus.commit_pos_out[7:4], tbl[r].e_p1);
    end

    // Fill to capacity; the extra issue is ignored
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.issue_en_in = 1'b1;
      bus.issue_instr_id_in = 6'(i);
      tick();
    end
    chk("fill_full", bus.full_out, 1);
    chk("fill_count", bus.count_out, 16);
    chk("fill_alloc", bus.alloc_pos_out, 0);
    tick();
    chk("over_count", bus.count_out, 16);
    chk("over_alloc", bus.alloc_pos_out, 0);
    chk("over_empty", bus.empty_out, 0);
    idle();

    // Partial flush keeps pos 0..2 and drops the concurrent issue
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.issue_en_in = 1'b1;
      tick();
    end
    idle();
    bus.ex_wb_en_in = 1'b1; bus.ex_wb_pos_in = 4'd4; bus.ex_res_in = 32'h44;
    tick();
    idle();
    bus.flush_part_en_in = 1'b1; bus.flush_part_pos_in = 4'd2; bus.issue_en_in = 1'b1;
    tick();
    idle();
    chk("pf_count", bus.count_out, 3);
    chk("pf_alloc", bus.alloc_pos_out, 3);
    chk("pf_commit_en", bus.commit_en_out, 0);
    for (int p = 3; p < 6; p++) begin
      bus.rs1_pos_in = 4'(p);
      #1;
      chk("pf_rs1_ready", bus.rs1_ready_out, 0);
    end
    bus.rs2_pos_in = 4'd2;
    #1;
    chk("pf_rs2_ready", bus.rs2_ready_out, 0);

    // Same-cycle load bypass
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.issue_en_in = 1'b1;
      tick();
    end
    idle();
    bus.rs1_pos_in = 4'd4; bus.rs2_pos_in = 4'd3;
    #1;
    chk("byp_before", bus.rs1_ready_out, 0);
    bus.ld_wb_en_in = 1'b1; bus.ld_wb_pos_in = 4'd4; bus.ld_res_in = 32'hDEADBEEF;
    #1;
    chk("byp_ready", bus.rs1_ready_out, 1);
    chk("byp_res", bus.rs1_res_out, 32'hDEADBEEF);
    chk("byp_other", bus.rs2_ready_out, 0);
    tick();
    bus.ld_wb_en_in = 1'b0;
    #1;
    chk("stored_ready", bus.rs1_ready_out, 1);
    chk("stored_res", bus.rs1_res_out, 32'hDEADBEEF);

    // Asynchronous reset while a commit is being presented
    do_reset();
    bus.issue_en_in = 1'b1;
    tick();
    tick();
    idle();
    bus.ex_wb_en_in = 1'b1; bus.ex_wb_pos_in = 4'd0; bus.ex_res_in = 32'h5;
    tick();
    bus.ex_wb_pos_in = 4'd1;
    tick();
    idle();
    chk("pre_rst_commit", bus.commit_en_out, 2'b01);
    chk("pre_rst_empty", bus.empty_out, 0);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("async_commit_en", bus.commit_en_out, 0);
    chk("async_empty", bus.empty_out, 1);

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      #1;
      check_comb();
      model_edge();
      tick();
      check_commit();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
